// File: rtl/diff_pkg.sv
// Shared definitions for the differential PSK chain: mode codes, Q1.15 constants,
// the packed {I,Q} sample type and the Gray-coded dibit mapper.
package diff_pkg;

    localparam logic [2:0] MODE_DBPSK = 3'd0;
    localparam logic [2:0] MODE_DQPSK = 3'd1;

    localparam logic signed [15:0] Q15_P1 = 16'sd32767;
    localparam logic signed [15:0] Q15_M1 = -16'sd32767;
    localparam logic signed [15:0] Q15_Z0 = 16'sd0;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
    } iq_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } mapper_state_t;

    // Gray mapping: 00 -> +1, 01 -> +j, 11 -> -1, 10 -> -j, scaled by amp.
    function automatic iq_t map_dibit(input logic [1:0] dibit, input logic signed [15:0] amp);
        iq_t                s;
        logic signed [15:0] neg;
        neg = -amp;
        s.i = Q15_Z0;
        s.q = Q15_Z0;
        case (dibit)
            2'b00:   s.i = amp;
            2'b01:   s.q = amp;
            2'b11:   s.i = neg;
            default: s.q = neg;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/diff_symbol_lut.sv
// Combinational symbol lookup: leading bits of the current byte plus mode -> {I,Q}.
module diff_symbol_lut
    import diff_pkg::*;
#(
    parameter logic signed [15:0] AMP = 16'sd32767
) (
    input  logic [1:0] bits,
    input  logic [2:0] mode,
    output iq_t        sym
);

    // A DBPSK bit b is the dibit {b,b}: 00 gives +AMP and 11 gives -AMP on I.
    always_comb begin
        if (mode == MODE_DQPSK) begin
            sym = map_dibit(bits, AMP);
        end else begin
            sym = map_dibit({bits[1], bits[1]}, AMP);
        end
    end

endmodule

// File: rtl/diff_symbol_mapper.sv
// Byte stream to differential phase-increment symbols (DBPSK 8 or DQPSK 4 per byte),
// with a registered AXI-Stream style output and a running accepted-symbol count.
module diff_symbol_mapper
    import diff_pkg::*;
#(
    parameter logic signed [15:0] AMP       = 16'sd32767,
    parameter bit                 MSB_FIRST = 1'b1
) (
    input  logic        clk_bb,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [2:0]  mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        mode_err,
    output logic [31:0] sym_count
);

    mapper_state_t state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    sym_left_q, sym_left_d;
    logic          last_q, last_d;
    logic [2:0]    mode_q, mode_d;
    iq_t           out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          mode_err_q, mode_err_d;
    logic [31:0]   sym_count_q, sym_count_d;

    logic          legal_mode;
    logic          accept;
    logic          fire;
    logic          load;
    logic [7:0]    in_bits;
    iq_t           lut_sym;

    assign legal_mode = (mode == MODE_DBPSK) || (mode == MODE_DQPSK);
    assign in_ready   = enable && legal_mode &&
                        ((state_q == ST_IDLE) || ((sym_left_q == 4'd1) && out_ready));
    assign accept     = in_valid && in_ready;
    assign fire       = (state_q == ST_EMIT) && out_ready;

    // The shift register always consumes from bit 7, so LSB-first bytes are reversed on load.
    always_comb begin
        in_bits = in_data;
        if (!MSB_FIRST) begin
            for (int k = 0; k < 8; k++) begin
                in_bits[k] = in_data[7 - k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        sym_left_d  = sym_left_q;
        last_d      = last_q;
        mode_d      = mode_q;
        sym_count_d = sym_count_q;
        load        = 1'b0;
        mode_err_d  = mode_err_q ||
                      ((state_q == ST_IDLE) && enable && in_valid && !legal_mode);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            ST_EMIT: begin
                if (fire) begin
                    sym_count_d = sym_count_q + 32'd1;
                    if (sym_left_q == 4'd1) begin
                        if (accept) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shift_d    = (mode_q == MODE_DQPSK) ? {shift_q[5:0], 2'b00}
                                                            : {shift_q[6:0], 1'b0};
                        sym_left_d = sym_left_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Mode is captured per byte so a mid-byte change only affects the next byte.
        if (load) begin
            state_d    = ST_EMIT;
            shift_d    = in_bits;
            last_d     = in_last;
            mode_d     = mode;
            sym_left_d = (mode == MODE_DQPSK) ? 4'd4 : 4'd8;
        end
    end

    diff_symbol_lut #(
        .AMP (AMP)
    ) u_lut (
        .bits (shift_d[7:6]),
        .mode (mode_d),
        .sym  (lut_sym)
    );

    // Output register follows the next symbol; when stalled shift_d equals shift_q so it holds.
    always_comb begin
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (state_d == ST_EMIT) begin
            out_data_d = lut_sym;
            out_last_d = last_d && (sym_left_d == 4'd1);
        end
    end

    always_ff @(posedge clk_bb) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            sym_left_q  <= '0;
            last_q      <= 1'b0;
            mode_q      <= MODE_DBPSK;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            mode_err_q  <= 1'b0;
            sym_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            sym_left_q  <= sym_left_d;
            last_q      <= last_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            mode_err_q  <= mode_err_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign mode_err  = mode_err_q;
    assign sym_count = sym_count_q;

endmodule
